// File: rtl/opb_register_bank_simulink2ppc.sv
// rtl/opb_register_bank_simulink2ppc.sv - OPB slave register bank exposing captured user channels
// Offset 0 is control/status (arm bit, capture count); offsets 1..C_NUM_CH are channel words.
module opb_register_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h01008100,
  parameter logic [31:0] C_HIGHADDR   = 32'h010081FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_CH     = 4,
  parameter int          C_DATA_WIDTH = 32,
  parameter int          C_MODE       = 0
) (
  input  logic                               OPB_Clk,
  input  logic                               OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]            OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]          OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]            OPB_DBus,
  input  logic                               OPB_RNW,
  input  logic                               OPB_select,
  input  logic                               OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]            Sl_DBus,
  output logic                               Sl_xferAck,
  output logic                               Sl_errAck,
  output logic                               Sl_retry,
  output logic                               Sl_toutSup,
  input  logic [C_NUM_CH*C_DATA_WIDTH-1:0]   user_data_in,
  input  logic                               user_valid,
  output logic                               snap_armed
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t                            state_q;
  logic                              ack_q;
  logic [31:0]                       dbus_q;
  logic                              arm_req_q;
  logic                              armed_q;
  logic                              hold_q;
  logic [7:0]                        count_q;
  logic [C_NUM_CH*C_DATA_WIDTH-1:0]  ch_q;

  logic [31:0] addr;
  logic [31:0] diff;
  logic [29:0] offset;
  logic        in_range;
  logic        capture;
  logic        arm_hit;
  logic [31:0] rd_data_d;
  logic        unused_inputs;

  assign addr     = 32'(OPB_ABus);
  assign diff     = addr - C_BASEADDR;
  assign offset   = diff[31:2];
  assign in_range = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);

  assign capture = (C_MODE == 0) ? user_valid : (armed_q && user_valid);
  assign arm_hit = (C_MODE == 1) && !OPB_RNW && (offset == '0) &&
                   OPB_BE[C_OPB_DWIDTH/8-1] && OPB_DBus[C_OPB_DWIDTH-1];

  assign unused_inputs = &{1'b0, OPB_seqAddr, OPB_BE[0:C_OPB_DWIDTH/8-2],
                           OPB_DBus[0:C_OPB_DWIDTH-2], diff[1:0]};

  always_comb begin
    rd_data_d = '0;
    if (offset == '0) rd_data_d = {16'h0, count_q, 7'h0, armed_q};
    for (int k = 0; k < C_NUM_CH; k++) begin
      if (offset == 30'(k + 1)) rd_data_d = 32'(ch_q[k*C_DATA_WIDTH +: C_DATA_WIDTH]);
    end
  end

  // hold_q blocks a select left asserted across reset from starting a new transfer.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q   <= S_IDLE;
      ack_q     <= 1'b0;
      dbus_q    <= '0;
      arm_req_q <= 1'b0;
      armed_q   <= 1'b0;
      hold_q    <= 1'b1;
      count_q   <= '0;
    end else begin
      if (!OPB_select) hold_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (OPB_select && in_range && !hold_q) begin
            state_q   <= S_ACK;
            ack_q     <= 1'b1;
            dbus_q    <= OPB_RNW ? rd_data_d : '0;
            arm_req_q <= arm_hit;
          end
        end
        S_ACK: begin
          state_q   <= S_WAIT;
          ack_q     <= 1'b0;
          dbus_q    <= '0;
          arm_req_q <= 1'b0;
        end
        S_WAIT: begin
          if (!OPB_select) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      // Arm takes effect after the ack cycle, so capture can never coincide with it.
      if (capture) begin
        armed_q <= 1'b0;
        count_q <= count_q + 8'd1;
      end else if (state_q == S_ACK && arm_req_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) ch_q <= '0;
    else if (capture) ch_q <= user_data_in;
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;
  assign snap_armed = armed_q;

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// tb/tb_opb_register_bank_simulink2ppc.sv - scoreboard bench for continuous and one-shot register banks
module tb_opb_register_bank_simulink2ppc;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  abus;
  logic [3:0]   be;
  logic [31:0]  dbus_w;
  logic         rnw;
  logic         sel0, sel1;
  logic         seqaddr;
  logic [47:0]  ud0;
  logic [127:0] ud1;
  logic         uv0, uv1;
  logic [31:0]  dbus0, dbus1;
  logic         ack0, ack1, err0, err1, retry0, retry1, tout0, tout1;
  logic         armed0, armed1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  opb_register_bank_simulink2ppc #(.C_NUM_CH(4), .C_DATA_WIDTH(12), .C_MODE(0)) dut0 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_w),
    .OPB_RNW(rnw), .OPB_select(sel0), .OPB_seqAddr(seqaddr), .Sl_DBus(dbus0),
    .Sl_xferAck(ack0), .Sl_errAck(err0), .Sl_retry(retry0), .Sl_toutSup(tout0),
    .user_data_in(ud0), .user_valid(uv0), .snap_armed(armed0));

  opb_register_bank_simulink2ppc #(.C_NUM_CH(4), .C_DATA_WIDTH(32), .C_MODE(1)) dut1 (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_w),
    .OPB_RNW(rnw), .OPB_select(sel1), .OPB_seqAddr(seqaddr), .Sl_DBus(dbus1),
    .Sl_xferAck(ack1), .Sl_errAck(err1), .Sl_retry(retry1), .Sl_toutSup(tout1),
    .user_data_in(ud1), .user_valid(uv1), .snap_armed(armed1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic xfer(input int d, input logic [31:0] addr, input logic rd,
                      input logic [31:0] wdata, input logic [3:0] be_i, input int hold,
                      input int exp_acks, input logic [31:0] exp, input string tag);
    int acks;
    logic [31:0] got;
    acks = 0;
    if (rd && exp_acks > 0) exp_q.push_back(exp);
    abus = addr; rnw = rd; dbus_w = wdata; be = be_i;
    if (d == 0) sel0 = 1'b1; else sel1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((d == 0) ? ack0 : ack1) begin
        acks++;
        got = (d == 0) ? dbus0 : dbus1;
        if (rd && exp_q.size() > 0) check({tag, "_data"}, got, exp_q.pop_front());
      end
      if (c + 1 >= hold && (acks > 0 || exp_acks == 0)) break;
    end
    sel0 = 1'b0; sel1 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if ((d == 0) ? ack0 : ack1) acks++;
    end
    check({tag, "_acks"}, 32'(acks), 32'(exp_acks));
    if (rd && exp_acks > 0) check({tag, "_idle"}, (d == 0) ? dbus0 : dbus1, 32'h0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    rst = 1'b1; abus = '0; be = '0; dbus_w = '0; rnw = 1'b1;
    sel0 = 1'b0; sel1 = 1'b0; seqaddr = 1'b0;
    ud0 = '0; ud1 = '0; uv0 = 1'b0; uv1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack0", {31'h0, ack0}, 32'h0);
    check("rst_dbus0", dbus0, 32'h0);
    check("rst_armed1", {31'h0, armed1}, 32'h0);
    check("tied_outs", {29'h0, err0 | err1, retry0 | retry1, tout0 | tout1}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // continuous mode, 12-bit channels
    ud0 = {12'hFED, 12'hABC, 12'h456, 12'h123};
    uv0 = 1'b1;
    @(negedge clk);
    uv0 = 1'b0;
    xfer(0, 32'h0100810C, 1'b1, 0, 4'hF, 1, 1, 32'h00000ABC, "m0_ch2");
    xfer(0, 32'h01008104, 1'b1, 0, 4'hF, 1, 1, 32'h00000123, "m0_ch0");
    xfer(0, 32'h01008100, 1'b1, 0, 4'hF, 1, 1, 32'h00000100, "m0_status");
    xfer(0, 32'h01008108, 1'b0, 32'hFFFFFFFF, 4'hF, 1, 1, 0, "m0_wr_ch1");
    xfer(0, 32'h01008108, 1'b1, 0, 4'hF, 1, 1, 32'h00000456, "m0_ch1_kept");
    xfer(0, 32'h0100811C, 1'b1, 0, 4'hF, 5, 1, 32'h00000000, "m0_off7_hold5");
    xfer(0, 32'h01008114, 1'b1, 0, 4'hF, 1, 1, 32'h00000000, "m0_off5");
    xfer(0, 32'h01008114, 1'b0, 32'h12345678, 4'hF, 1, 1, 0, "m0_wr_off5");
    xfer(0, 32'h01008200, 1'b1, 0, 4'hF, 4, 0, 0, "m0_above");
    xfer(0, 32'h010080FC, 1'b1, 0, 4'hF, 4, 0, 0, "m0_below");
    xfer(0, 32'h01008100, 1'b0, 32'h00000001, 4'hF, 1, 1, 0, "m0_arm");
    check("m0_never_armed", {31'h0, armed0}, 32'h0);

    ud0 = {12'h5A5, 12'h0F0, 12'h00F, 12'h321};
    uv0 = 1'b1;
    repeat (255) @(negedge clk);
    uv0 = 1'b0;
    xfer(0, 32'h01008100, 1'b1, 0, 4'hF, 1, 1, 32'h00000000, "m0_wrap");
    xfer(0, 32'h01008110, 1'b1, 0, 4'hF, 1, 1, 32'h000005A5, "m0_ch3");

    ud0 = {12'h5A5, 12'h0F0, 12'h00F, 12'h777};
    uv0 = 1'b1;
    xfer(0, 32'h01008104, 1'b1, 0, 4'hF, 1, 1, 32'h00000321, "m0_precap");
    uv0 = 1'b0;
    xfer(0, 32'h01008104, 1'b1, 0, 4'hF, 1, 1, 32'h00000777, "m0_postcap");

    // one-shot mode, 32-bit channels
    ud1 = {96'h0, 32'hDEADBEEF};
    uv1 = 1'b1;
    repeat (3) @(negedge clk);
    uv1 = 1'b0;
    xfer(1, 32'h01008104, 1'b1, 0, 4'hF, 1, 1, 32'h00000000, "m1_unarmed_ch0");
    xfer(1, 32'h01008100, 1'b0, 32'h00000001, 4'hF, 1, 1, 0, "m1_arm");
    check("m1_armed", {31'h0, armed1}, 32'h1);
    ud1 = {96'h0, 32'h11111111};
    repeat (3) @(negedge clk);
    xfer(1, 32'h01008104, 1'b1, 0, 4'hF, 1, 1, 32'h00000000, "m1_novalid_ch0");
    check("m1_still_armed", {31'h0, armed1}, 32'h1);
    xfer(1, 32'h01008100, 1'b1, 0, 4'hF, 1, 1, 32'h00000001, "m1_status_armed");
    xfer(1, 32'h01008100, 1'b0, 32'h00000001, 4'hF, 1, 1, 0, "m1_rearm");
    check("m1_rearm_noop", {31'h0, armed1}, 32'h1);

    ud1 = {64'h0, 32'hCAFEF00D, 32'h12345678};
    uv1 = 1'b1;
    @(negedge clk);
    uv1 = 1'b0;
    check("m1_disarmed", {31'h0, armed1}, 32'h0);
    ud1 = {128{1'b1}};
    uv1 = 1'b1;
    @(negedge clk);
    uv1 = 1'b0;
    xfer(1, 32'h01008104, 1'b1, 0, 4'hF, 1, 1, 32'h12345678, "m1_ch0");
    xfer(1, 32'h01008108, 1'b1, 0, 4'hF, 1, 1, 32'hCAFEF00D, "m1_ch1");
    xfer(1, 32'h01008100, 1'b1, 0, 4'hF, 1, 1, 32'h00000100, "m1_status");
    xfer(1, 32'h01008100, 1'b0, 32'h00000002, 4'hF, 1, 1, 0, "m1_arm_bit0_clear");
    check("m1_arm_bit0_ignored", {31'h0, armed1}, 32'h0);
    xfer(1, 32'h01008100, 1'b0, 32'h00000001, 4'hE, 1, 1, 0, "m1_arm_be_clear");
    check("m1_arm_be_ignored", {31'h0, armed1}, 32'h0);

    // valid during the arm ack must not capture; first capture is the next cycle
    ud1 = {96'h0, 32'hAAAA0001};
    uv1 = 1'b1;
    abus = 32'h01008100; rnw = 1'b0; dbus_w = 32'h00000001; be = 4'hF; sel1 = 1'b1;
    @(negedge clk);
    check("m1_armack_ack", {31'h0, ack1}, 32'h1);
    check("m1_armack_armed", {31'h0, armed1}, 32'h0);
    sel1 = 1'b0;
    @(negedge clk);
    check("m1_armed_after_ack", {31'h0, armed1}, 32'h1);
    ud1 = {96'h0, 32'hBBBB0002};
    @(negedge clk);
    uv1 = 1'b0;
    check("m1_armack_disarmed", {31'h0, armed1}, 32'h0);
    @(negedge clk);
    xfer(1, 32'h01008104, 1'b1, 0, 4'hF, 1, 1, 32'hBBBB0002, "m1_armack_ch0");
    xfer(1, 32'h01008100, 1'b1, 0, 4'hF, 1, 1, 32'h00000200, "m1_armack_status");

    // reset in the middle of an acknowledged read
    xfer(1, 32'h01008100, 1'b0, 32'h00000001, 4'hF, 1, 1, 0, "m1_arm_prerst");
    abus = 32'h01008104; rnw = 1'b1; sel1 = 1'b1;
    @(negedge clk);
    check("rst_mid_ack", {31'h0, ack1}, 32'h1);
    rst = 1'b1;
    #1;
    check("rst_ack_drop", {31'h0, ack1}, 32'h0);
    check("rst_dbus_drop", dbus1, 32'h0);
    check("rst_armed_drop", {31'h0, armed1}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack1) acks++;
    end
    check("rst_no_ack_held_sel", 32'(acks), 32'h0);
    sel1 = 1'b0;
    @(negedge clk);
    xfer(1, 32'h01008104, 1'b1, 0, 4'hF, 1, 1, 32'h00000000, "rst_m1_ch0");
    xfer(1, 32'h01008100, 1'b1, 0, 4'hF, 1, 1, 32'h00000000, "rst_m1_status");
    xfer(0, 32'h0100810C, 1'b1, 0, 4'hF, 1, 1, 32'h00000000, "rst_m0_ch2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
